// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: resolves bne/blt/j/jal/jr and detects direction
// mispredicts. Drives a registered redirect to fetch and trains a 2-bit BHT.
module branch_resolve #(
   parameter int IDX_BITS  = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ex_valid,
   input  logic [2:0]           ex_type,
   input  logic [31:0]          ex_pc,
   input  logic [31:0]          ex_imm,
   input  logic [31:0]          ex_target,
   input  logic                 ex_pred_taken,
   input  logic                 isLessThan,
   input  logic                 isNotEqual,
   input  logic                 stall,
   input  logic [31:0]          fetch_pc,
   output logic                 fetch_pred_taken,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   output logic [CNT_WIDTH-1:0] mispredict_count
);

   localparam int unsigned DEPTH = 2 ** IDX_BITS;

   typedef enum logic {
      IDLE,
      SHADOW
   } state_t;

   state_t state, stateNext;

   logic [1:0]          bht [DEPTH];
   logic                isBranch, isJump, taken, accept, needRedirect;
   logic [31:0]         seqPc, nextPc;
   logic [IDX_BITS-1:0] exIdx, fetchIdx;
   logic                unusedFetchBits;

   assign exIdx           = ex_pc[IDX_BITS-1:0];
   assign fetchIdx        = fetch_pc[IDX_BITS-1:0];
   assign unusedFetchBits = ^fetch_pc[31:IDX_BITS];

   // Read-before-write: the BHT is only written at the clock edge, so a same-cycle
   // lookup of the entry being trained naturally sees the old counter.
   assign fetch_pred_taken = bht[fetchIdx][1];

   always_comb begin
      isBranch     = 1'b0;
      isJump       = 1'b0;
      taken        = 1'b0;
      seqPc        = ex_pc + 32'd1;
      nextPc       = seqPc;
      case (ex_type)
         3'd1: begin
            isBranch = 1'b1;
            taken    = isNotEqual;
         end
         3'd2: begin
            isBranch = 1'b1;
            taken    = isLessThan;
         end
         3'd3, 3'd4, 3'd5: begin
            isJump = 1'b1;
            taken  = 1'b1;
         end
         default: ;
      endcase
      if (taken) begin
         nextPc = isBranch ? (seqPc + ex_imm) : ex_target;
      end
      accept       = ex_valid && !stall && (state == IDLE) && (isBranch || isJump);
      needRedirect = isJump || (isBranch && (taken != ex_pred_taken));
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept && needRedirect) stateNext = SHADOW;
         SHADOW:  if (!stall) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         redirect_valid   <= 1'b0;
         redirect_pc      <= '0;
         mispredict_count <= '0;
      end else begin
         redirect_valid <= accept && needRedirect;
         if (accept && needRedirect) begin
            redirect_pc <= nextPc;
         end
         if (accept && isBranch && needRedirect && (mispredict_count != '1)) begin
            mispredict_count <= mispredict_count + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            bht[IDX_BITS'(i)] <= 2'b01;
         end
      end else if (accept && isBranch) begin
         if (taken && (bht[exIdx] != 2'b11)) begin
            bht[exIdx] <= bht[exIdx] + 2'b01;
         end else if (!taken && (bht[exIdx] != 2'b00)) begin
            bht[exIdx] <= bht[exIdx] - 2'b01;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, randomized run against a
// behavioural model, and a counter saturation sequence (narrow counter instance).
module tb_branch_resolve;

   localparam int IDX = 4;
   localparam int CW  = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          ex_valid = 1'b0;
   logic [2:0]    ex_type = '0;
   logic [31:0]   ex_pc = '0;
   logic [31:0]   ex_imm = '0;
   logic [31:0]   ex_target = '0;
   logic          ex_pred_taken = 1'b0;
   logic          isLessThan = 1'b0;
   logic          isNotEqual = 1'b0;
   logic          stall = 1'b0;
   logic [31:0]   fetch_pc = '0;
   logic          fetch_pred_taken;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic [CW-1:0] mispredict_count;

   branch_resolve #(.IDX_BITS(IDX), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_type(ex_type),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .isLessThan(isLessThan), .isNotEqual(isNotEqual),
      .stall(stall), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mispredict_count(mispredict_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          rst, valid;
      logic [2:0]  typ;
      logic [31:0] pc, imm, tgt;
      bit          pred, lt, ne, stl;
      logic [31:0] fpc;
      bit          expRv;
      logic [31:0] expPc;
      int          expCnt;
      bit          expPred;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit rst, bit valid, logic [2:0] typ, logic [31:0] pc,
                               logic [31:0] imm, logic [31:0] tgt, bit pred, bit lt, bit ne,
                               bit stl, logic [31:0] fpc, bit expRv, logic [31:0] expPc,
                               int expCnt, bit expPred);
      vec_t v;
      v.rst = rst; v.valid = valid; v.typ = typ; v.pc = pc; v.imm = imm; v.tgt = tgt;
      v.pred = pred; v.lt = lt; v.ne = ne; v.stl = stl; v.fpc = fpc;
      v.expRv = expRv; v.expPc = expPc; v.expCnt = expCnt; v.expPred = expPred;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(bit rst, bit valid, logic [2:0] typ, logic [31:0] pc, logic [31:0] imm,
                        logic [31:0] tgt, bit pred, bit lt, bit ne, bit stl, logic [31:0] fpc);
      reset = rst; ex_valid = valid; ex_type = typ; ex_pc = pc; ex_imm = imm;
      ex_target = tgt; ex_pred_taken = pred; isLessThan = lt; isNotEqual = ne;
      stall = stl; fetch_pc = fpc;
   endtask

   // Behavioural reference: architectural rules applied once per clock edge.
   int          mBht[16];
   int          mCnt;
   bit          mShadow;
   bit          mRv;
   logic [31:0] mPc;

   task automatic modelReset();
      foreach (mBht[i]) mBht[i] = 1;
      mCnt = 0; mShadow = 0; mRv = 0; mPc = 0;
   endtask

   task automatic modelEdge();
      bit          isBr, isJmp, acc, tk;
      logic [31:0] dest;
      if (!reset) begin
         modelReset();
         return;
      end
      isBr  = (ex_type == 3'd1) || (ex_type == 3'd2);
      isJmp = (ex_type >= 3'd3) && (ex_type <= 3'd5);
      acc   = ex_valid && !stall && !mShadow && (isBr || isJmp);
      mRv   = 0;
      if (mShadow && !stall) mShadow = 0;
      if (acc) begin
         tk = (ex_type == 3'd1) ? isNotEqual : (ex_type == 3'd2) ? isLessThan : 1'b1;
         if (!tk)       dest = ex_pc + 1;
         else if (isBr) dest = ex_pc + 1 + ex_imm;
         else           dest = ex_target;
         if (isBr) begin
            int k = int'(ex_pc[3:0]);
            if (tk) mBht[k] = (mBht[k] < 3) ? mBht[k] + 1 : 3;
            else    mBht[k] = (mBht[k] > 0) ? mBht[k] - 1 : 0;
            if (tk != ex_pred_taken) mCnt = (mCnt < CNT_MAX) ? mCnt + 1 : CNT_MAX;
         end
         if (isJmp || tk != ex_pred_taken) begin
            mRv = 1; mPc = dest; mShadow = 1;
         end
      end
   endtask

   initial begin
      // rst valid typ pc imm tgt pred lt ne stall fpc | rv pc cnt pred
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,5,                        0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,5,                        0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,5,                        0,0,0,0));
      vecs.push_back(mk(1,1,1,'h10,'hFFFFFFFC,0,0,0,1,0,'h10,         1,'h0D,1,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,'h10,                     0,'h0D,1,1));
      vecs.push_back(mk(1,1,2,3,0,0,1,1,0,0,3,                        0,'h0D,1,1));
      vecs.push_back(mk(1,1,2,3,0,0,1,1,0,0,3,                        0,'h0D,1,1));
      vecs.push_back(mk(1,1,2,3,0,0,1,1,0,0,3,                        0,'h0D,1,1));
      vecs.push_back(mk(1,1,2,3,0,0,1,0,0,0,3,                        1,4,2,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,3,                        0,4,2,1));
      vecs.push_back(mk(1,1,5,'h50,0,'h200,0,0,0,0,0,                 1,'h200,2,1));
      vecs.push_back(mk(1,1,1,0,0,0,1,0,0,0,0,                        0,'h200,2,1));
      vecs.push_back(mk(1,1,3,'h60,0,'h40,0,0,0,0,0,                  1,'h40,2,1));
      vecs.push_back(mk(1,1,1,0,0,0,0,0,1,1,0,                        0,'h40,2,1));
      vecs.push_back(mk(1,1,1,0,0,0,0,0,1,1,0,                        0,'h40,2,1));
      vecs.push_back(mk(1,1,1,0,0,0,0,0,1,1,0,                        0,'h40,2,1));
      vecs.push_back(mk(1,1,1,0,0,0,0,0,1,0,0,                        0,'h40,2,1));
      vecs.push_back(mk(1,1,1,0,0,0,0,0,1,1,0,                        0,'h40,2,1));
      vecs.push_back(mk(1,1,2,'hFFFFFFFF,0,0,1,0,0,0,'hF,             1,0,3,0));
      vecs.push_back(mk(0,1,1,0,0,0,0,0,1,0,'h10,                     0,0,0,0));
      vecs.push_back(mk(1,1,1,'h20,8,0,0,0,1,0,0,                     1,'h29,1,1));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].typ, vecs[i].pc, vecs[i].imm, vecs[i].tgt,
               vecs[i].pred, vecs[i].lt, vecs[i].ne, vecs[i].stl, vecs[i].fpc);
         tick();
         check($sformatf("vec%0d.redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].expRv));
         check($sformatf("vec%0d.redirect_pc", i), redirect_pc, vecs[i].expPc);
         check($sformatf("vec%0d.mispredict_count", i), 32'(mispredict_count), 32'(vecs[i].expCnt));
         check($sformatf("vec%0d.fetch_pred_taken", i), 32'(fetch_pred_taken), 32'(vecs[i].expPred));
      end

      // Randomized run against the model.
      drive(0,0,0,0,0,0,0,0,0,0,0);
      modelEdge();
      tick();
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] pc;
         pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
               3'($urandom_range(0, 7)), pc, ($urandom_range(0, 1) != 0) ? $urandom : 32'd3,
               $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 63)));
         modelEdge();
         tick();
         check("rnd.redirect_valid", 32'(redirect_valid), 32'(mRv));
         check("rnd.redirect_pc", redirect_pc, mPc);
         check("rnd.mispredict_count", 32'(mispredict_count), 32'(mCnt));
         check("rnd.fetch_pred_taken", 32'(fetch_pred_taken),
               32'(mBht[int'(fetch_pc[3:0])] >= 2));
      end

      // Counter saturation: each mispredict is followed by its shadow cycle.
      drive(0,0,0,0,0,0,0,0,0,0,0);
      tick();
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         drive(1,1,1,32'($urandom_range(0, 15)),0,0,0,0,1,0,0);
         tick();
         if (i == 100 || i == CNT_MAX - 2 || i == CNT_MAX - 1 || i == CNT_MAX + 4) begin
            check($sformatf("sat%0d.mispredict_count", i), 32'(mispredict_count),
                  32'((i + 1 < CNT_MAX) ? i + 1 : CNT_MAX));
         end
         drive(1,0,0,0,0,0,0,0,0,0,0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
